// File: rtl/core_dmem_bridge_pkg.sv
// Shared encodings and request-classification helpers for the data-memory bridge.
package core_dmem_bridge_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } dmem_size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } dmem_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_e;

  // Unsigned widths only make sense for loads.
  function automatic logic size_legal(input logic [2:0] size, input logic we);
    case (size)
      SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
      SZ_BU, SZ_HU:     size_legal = ~we;
      default:          size_legal = 1'b0;
    endcase
  endfunction

  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      SZ_H, SZ_HU: size_aligned = ~off[0];
      SZ_W:        size_aligned = (off == 2'b00);
      default:     size_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/core_dmem_bridge_if.sv
// Word-aligned req/ack data bus between the bridge (master) and data memory (slave).
interface core_dmem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/core_dmem_align.sv
// Byte-lane steering for stores/byte enables and lane extraction with extension for loads.
module core_dmem_align
  import core_dmem_bridge_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane;

  // funct3[1:0] carries the access width for both signed and unsigned codes.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (st_size_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane      = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = lane;
    case (ld_size_i)
      SZ_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
      SZ_BU:   ld_data_o = {24'h000000, lane[7:0]};
      SZ_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
      SZ_HU:   ld_data_o = {16'h0000, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/core_dmem_bridge.sv
// Multi-cycle load/store stage: classifies requests, runs one bus transfer at a time,
// stalls the core meanwhile and reports completion, misalignment, illegal size or timeout.
module core_dmem_bridge
  import core_dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_size_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  core_dmem_bridge_if.master    mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  dmem_err_e             err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  legal, aligned;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [31:0]           ld_data;

  core_dmem_align u_align (
    .st_size_i (req_size_i),
    .st_off_i  (req_addr_i[1:0]),
    .st_data_i (req_wdata_i),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .rdata_i   (mem.mem_rdata_i),
    .ld_data_o (ld_data)
  );

  assign legal   = size_legal(req_size_i, req_we_i);
  assign aligned = size_aligned(req_size_i, req_addr_i[1:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    off_d       = off_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = ERR_NONE;
    rd_data_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (!legal) begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (!aligned) begin
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d     = ST_WAIT;
            cnt_d       = '0;
            we_d        = req_we_i;
            size_d      = req_size_i;
            off_d       = req_addr_i[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = req_we_i;
            mem_be_d    = st_be;
            mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = req_we_i ? st_wdata : '0;
          end
        end
      end
      ST_WAIT: begin
        // An ack arriving on the last permitted cycle still completes normally.
        if (mem.mem_ack_i) begin
          state_d   = ST_RESP;
          done_d    = 1'b1;
          rd_data_d = we_q ? '0 : ld_data;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_be_d    = mem_be_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Reset gates the combinational stall so every output is low while rst_i is held.
  assign stall_o = ~rst_i & (((state_q == ST_IDLE) & req_valid_i & legal & aligned) |
                             (state_q == ST_WAIT));

  assign done_o          = done_q;
  assign rd_data_o       = rd_data_q;
  assign err_o           = err_q;
  assign err_code_o      = err_code_q;
  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_be_o    = mem_be_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_core_dmem_bridge.sv
// Scoreboard bench: stimulus queues expected bus transfers and responses; a bus responder
// and a response monitor pop and compare independently.
module tb_core_dmem_bridge;
  import core_dmem_bridge_pkg::*;

  localparam int unsigned TO = 4;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] data;
    int unsigned cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned waits;
    logic        ack;
    logic        chk;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall_o, done_o, err_o;
  logic [31:0] rd_data_o;
  logic [1:0]  err_code_o;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int unsigned cyc = 0;
  resp_t       resp_q[$];
  bus_t        bq[$];
  resp_t       rm;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_dmem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  core_dmem_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_size_i  (req_size),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .rd_data_o   (rd_data_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .mem         (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && (done_o || err_o)) begin
      if (done_o) done_cnt++;
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got done=%0b err=%0b code=%0d, expected no response",
                 done_o, err_o, err_code_o);
      end else begin
        rm = resp_q.pop_front();
        check("resp_err", 32'(err_o), rm.is_err ? 1 : 0);
        check("resp_done", 32'(done_o), rm.is_err ? 0 : 1);
        if (rm.is_err) check("err_code", 32'(err_code_o), 32'(rm.code));
        else check("rd_data", rd_data_o, rm.data);
        check("resp_cycle", cyc, rm.cyc);
      end
    end
  end

  // Bus responder
  initial begin : responder
    bus_t        b;
    int unsigned n;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_o) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got req addr=0x%08h, expected no bus request", bus.mem_addr_o);
        end else begin
          b = bq.pop_front();
          check("bus_we", 32'(bus.mem_we_o), 32'(b.we));
          check("bus_be", 32'(bus.mem_be_o), 32'(b.be));
          check("bus_addr", bus.mem_addr_o, b.addr);
          check("bus_wdata", bus.mem_wdata_o, b.wdata);
          if (b.ack) begin
            for (int i = 0; i < int'(b.waits); i++) begin
              @(negedge clk);
              if (b.chk) begin
                check("bus_hold_req", 32'(bus.mem_req_o), 1);
                check("bus_hold_addr", bus.mem_addr_o, b.addr);
              end
            end
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = b.rdata;
            @(negedge clk);
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = '0;
            if (b.chk) check("bus_req_resp", 32'(bus.mem_req_o), 0);
          end else begin
            n = 1;
            while (bus.mem_req_o && n < 64) begin
              @(negedge clk);
              if (bus.mem_req_o) n++;
            end
            check("timeout_req_cycles", n, TO);
          end
        end
      end
    end
  end

  task automatic drain();
    int unsigned n = 0;
    while ((resp_q.size() != 0 || bq.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (resp_q.size() != 0 || bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d responses and %0d bus transfers outstanding, expected 0",
               resp_q.size(), bq.size());
      resp_q.delete();
      bq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int unsigned waits,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                        input logic [1:0] eerr);
    int unsigned k;
    resp_t       r;
    bus_t        b;
    logic        bad;
    k         = cyc;
    bad       = (eerr == ERR_MISALIGN) || (eerr == ERR_ILLEGAL);
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    if (bad) begin
      r = '{is_err: 1'b1, code: eerr, data: '0, cyc: k + 1};
      resp_q.push_back(r);
      #1 check("stall_err", 32'(stall_o), 0);
    end else begin
      b = '{we: we, be: ebe, addr: addr & ~32'h3, wdata: ewd, rdata: rdata,
            waits: waits, ack: (eerr != ERR_TIMEOUT), chk: 1'b1};
      bq.push_back(b);
      if (eerr == ERR_TIMEOUT) r = '{is_err: 1'b1, code: eerr, data: '0, cyc: k + 1 + TO};
      else r = '{is_err: 1'b0, code: 2'b00, data: erd, cyc: k + 2 + waits};
      resp_q.push_back(r);
      #1 check("stall_accept", 32'(stall_o), 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (bad) check("err_no_bus", 32'(bus.mem_req_o), 0);
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned dc;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_err_code", 32'(err_code_o), 0);
    check("rst_rd_data", rd_data_o, 0);
    check("rst_mem_req", 32'(bus.mem_req_o), 0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // we size addr wdata rdata waits | be wdata rd_data err
    access(1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0,        2, 4'b1000, 32'hA5A5A5A5, 32'h0,        ERR_NONE);
    access(1'b0, 3'b000, 32'h2001, 32'h0,        32'h00008000, 0, 4'b0010, 32'h0,        32'hFFFFFF80, ERR_NONE);
    access(1'b0, 3'b100, 32'h2001, 32'h0,        32'h00008000, 1, 4'b0010, 32'h0,        32'h00000080, ERR_NONE);
    access(1'b0, 3'b101, 32'h2002, 32'h0,        32'hBEEF0000, 0, 4'b1100, 32'h0,        32'h0000BEEF, ERR_NONE);
    access(1'b0, 3'b001, 32'h2002, 32'h0,        32'hBEEF0000, 3, 4'b1100, 32'h0,        32'hFFFFBEEF, ERR_NONE);
    access(1'b0, 3'b000, 32'h2003, 32'h0,        32'h7F000000, 0, 4'b1000, 32'h0,        32'h0000007F, ERR_NONE);
    access(1'b0, 3'b010, 32'h3000, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678, ERR_NONE);
    access(1'b1, 3'b001, 32'h1002, 32'h1234ABCD, 32'hFFFFFFFF, 0, 4'b1100, 32'hABCDABCD, 32'h0,        ERR_NONE);
    access(1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        ERR_NONE);
    access(1'b0, 3'b010, 32'h3002, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        ERR_MISALIGN);
    access(1'b0, 3'b001, 32'h2001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        ERR_MISALIGN);
    access(1'b1, 3'b101, 32'h2000, 32'h1111,     32'h0,        0, 4'b0000, 32'h0,        32'h0,        ERR_ILLEGAL);
    access(1'b0, 3'b011, 32'h2000, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        ERR_ILLEGAL);
    access(1'b0, 3'b010, 32'h5000, 32'h0,        32'h0,        0, 4'b1111, 32'h0,        32'h0,        ERR_TIMEOUT);
    access(1'b0, 3'b010, 32'h5004, 32'h0,        32'hCAFEF00D, 0, 4'b1111, 32'h0,        32'hCAFEF00D, ERR_NONE);
    access(1'b0, 3'b010, 32'h5008, 32'h0,        32'h0BADF00D, 3, 4'b1111, 32'h0,        32'h0BADF00D, ERR_NONE);

    // Asynchronous reset in the middle of a transfer, followed by a late acknowledge.
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h6000;
    req_valid = 1'b1;
    bq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h6000, wdata: 32'h0, rdata: 32'h11111111,
                   waits: 6, ack: 1'b1, chk: 1'b0});
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("req_before_rst", 32'(bus.mem_req_o), 1);
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", 32'(bus.mem_req_o), 0);
    check("rst_async_stall", 32'(stall_o), 0);
    check("rst_async_done", 32'(done_o), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("late_ack_no_done", 32'(done_cnt), 32'(dc));
    check("late_ack_stall", 32'(stall_o), 0);
    drain();

    // req_valid held across a whole access; new request during WAIT must not disturb the bus.
    begin : b2b
      int unsigned k;
      k         = cyc;
      req_we    = 1'b0;
      req_size  = 3'b010;
      req_addr  = 32'h7000;
      req_wdata = 32'h0;
      req_valid = 1'b1;
      bq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h7000, wdata: 32'h0, rdata: 32'hA0A0A0A0,
                     waits: 0, ack: 1'b1, chk: 1'b1});
      bq.push_back('{we: 1'b0, be: 4'b1000, addr: 32'h7000, wdata: 32'h0, rdata: 32'h5A000000,
                     waits: 0, ack: 1'b1, chk: 1'b1});
      resp_q.push_back('{is_err: 1'b0, code: 2'b00, data: 32'hA0A0A0A0, cyc: k + 2});
      resp_q.push_back('{is_err: 1'b0, code: 2'b00, data: 32'h0000005A, cyc: k + 5});
      @(posedge clk); #1;
      req_size = 3'b100;
      req_addr = 32'h7003;
      check("stall_wait", 32'(stall_o), 1);
      @(posedge clk); #1;
      check("stall_resp", 32'(stall_o), 0);
      @(posedge clk); #1;
      check("stall_b2b_accept", 32'(stall_o), 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      drain();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
